spi_burst_reader: RTL and testbench

Parametrised successor to the single-register SPI poller for the PmodACL2 (ADXL362) accelerometer. It reads NUM_BYTES consecutive registers from START_ADDR in one chip-select burst: read command 0x0B, then the address, then NUM_BYTES dummy bytes. The result is presented as one atomically updated bus. It sits between the byte-level SPI shift engine and the application logic. Bursts are started by a free-running poll timer or by an external trigger.

---
 rtl/spi_burst_reader_if.sv | 21 ++
 rtl/spi_burst_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_burst_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_burst_reader_if.sv
// Byte-level handshake between the burst reader (master) and the SPI shift engine (slave).
interface spi_burst_reader_if;
    logic [7:0] spi_tx_data;
    logic       start;
    logic [7:0] spi_rx_data;
    logic       spi_byte_done;

    modport master (
        output spi_tx_data,
        output start,
        input  spi_rx_data,
        input  spi_byte_done
    );

    modport slave (
        input  spi_tx_data,
        input  start,
        output spi_rx_data,
        output spi_byte_done
    );
endinterface

// File: rtl/spi_burst_reader.sv
// ADXL362 burst reader: one ncs_o window of 0x0B, START_ADDR, NUM_BYTES dummy reads -> data_o.
// SPI_BURST_INIT_WRITE_EN: one POWER_CTL measurement-mode write burst after reset, before any read.
module spi_burst_reader #(
    parameter int unsigned NUM_BYTES   = 6,
    parameter logic [7:0]  START_ADDR  = 8'h0E,
    parameter int unsigned POLL_PERIOD = 10000,
    parameter int unsigned NCS_GAP     = 8,
    parameter bit          AUTO_POLL   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trigger_i,
    spi_burst_reader_if.master     spi,
    output logic                   ncs_o,
    output logic                   clk_enable,
    output logic [NUM_BYTES*8-1:0] data_o,
    output logic                   data_valid,
    output logic                   busy,
    output logic                   overrun
);
    localparam int IDXW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int PCW  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int GW   = (NCS_GAP > 1) ? $clog2(NCS_GAP) : 1;
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_BYTES - 1);
    localparam logic [PCW-1:0]  POLL_LAST = PCW'(POLL_PERIOD - 1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'(NCS_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_DONE, S_GAP
`ifdef SPI_BURST_INIT_WRITE_EN
        , S_INIT_CMD, S_INIT_ADDR, S_INIT_DATA
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [PCW-1:0]         poll_q;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   pending_q, pending_d;
    logic [NUM_BYTES*8-1:0] shadow_q, shadow_d;
    logic [NUM_BYTES*8-1:0] data_q, data_d;
    logic [7:0]             tx_q, tx_d;
    logic                   start_q, start_d;
    logic                   ncs_q, ncs_d;
    logic                   clk_en_q, clk_en_d;
    logic                   dv_q, dv_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;
    logic                   tick, req, launch, queue_req;
`ifdef SPI_BURST_INIT_WRITE_EN
    logic                   init_done_q, init_done_d;
`endif

    assign tick = AUTO_POLL && (poll_q == POLL_LAST);
    assign req  = tick | trigger_i;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        tx_d      = tx_q;
        start_d   = 1'b0;
        ncs_d     = ncs_q;
        clk_en_d  = clk_en_q;
        dv_d      = 1'b0;
        busy_d    = busy_q;
        ovr_d     = 1'b0;
        launch    = 1'b0;
        queue_req = 1'b1;
`ifdef SPI_BURST_INIT_WRITE_EN
        init_done_d = init_done_q;
`endif
        case (state_q)
            S_IDLE: begin
                queue_req = 1'b0;
`ifdef SPI_BURST_INIT_WRITE_EN
                if (!init_done_q) begin
                    state_d   = S_INIT_CMD;
                    ncs_d     = 1'b0;
                    clk_en_d  = 1'b1;
                    busy_d    = 1'b1;
                    tx_d      = 8'h0A;
                    start_d   = 1'b1;
                    pending_d = req;
                end else
`endif
                if (req) launch = 1'b1;
            end
            S_CMD: if (spi.spi_byte_done) begin
                state_d = S_ADDR;
                tx_d    = START_ADDR;
                start_d = 1'b1;
            end
            S_ADDR: if (spi.spi_byte_done) begin
                state_d = S_READ;
                tx_d    = 8'h00;
                start_d = 1'b1;
                idx_d   = '0;
            end
            S_READ: if (spi.spi_byte_done) begin
                shadow_d[{idx_q, 3'b000} +: 8] = spi.spi_rx_data;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    start_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d  = S_GAP;
                gap_d    = '0;
                data_d   = shadow_q;
                dv_d     = 1'b1;
                ncs_d    = 1'b1;
                clk_en_d = 1'b0;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    queue_req = 1'b0;
                    // A pending request is consumed first; a fresh one this cycle re-arms pending.
                    if (pending_q || req) begin
                        launch    = 1'b1;
                        pending_d = pending_q && req;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
`ifdef SPI_BURST_INIT_WRITE_EN
            S_INIT_CMD: if (spi.spi_byte_done) begin
                state_d = S_INIT_ADDR;
                tx_d    = 8'h2D;
                start_d = 1'b1;
            end
            S_INIT_ADDR: if (spi.spi_byte_done) begin
                state_d = S_INIT_DATA;
                tx_d    = 8'h02;
                start_d = 1'b1;
            end
            S_INIT_DATA: if (spi.spi_byte_done) begin
                state_d     = S_GAP;
                gap_d       = '0;
                ncs_d       = 1'b1;
                clk_en_d    = 1'b0;
                init_done_d = 1'b1;
            end
`endif
            default: begin
                queue_req = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        if (launch) begin
            state_d  = S_CMD;
            ncs_d    = 1'b0;
            clk_en_d = 1'b1;
            busy_d   = 1'b1;
            tx_d     = 8'h0B;
            start_d  = 1'b1;
        end

        if (queue_req && req) begin
            if (pending_q) ovr_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            poll_q    <= '0;
            gap_q     <= '0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            data_q    <= '0;
            tx_q      <= 8'h00;
            start_q   <= 1'b0;
            ncs_q     <= 1'b1;
            clk_en_q  <= 1'b0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef SPI_BURST_INIT_WRITE_EN
            init_done_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            poll_q    <= (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            start_q   <= start_d;
            ncs_q     <= ncs_d;
            clk_en_q  <= clk_en_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
`ifdef SPI_BURST_INIT_WRITE_EN
            init_done_q <= init_done_d;
`endif
        end
    end

    assign spi.spi_tx_data = tx_q;
    assign spi.start       = start_q;
    assign ncs_o           = ncs_q;
    assign clk_enable      = clk_en_q;
    assign data_o          = data_q;
    assign data_valid      = dv_q;
    assign busy            = busy_q;
    assign overrun         = ovr_q;
endmodule

// File: tb/tb_spi_burst_reader.sv
// Bench for spi_burst_reader: randomized triggers/engine latency against a transaction-level model,
// plus a second trigger-only instance (NUM_BYTES=1, START_ADDR=0x14) for directed cases.
module tb_spi_burst_reader;
    localparam int         NB  = 6;
    localparam logic [7:0] SA  = 8'h0E;
    localparam int         PP  = 100;
    localparam int         GAP = 8;
`ifdef SPI_BURST_INIT_WRITE_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, trigger, ncs, clk_en, dv, busy, ovr;
    logic [NB*8-1:0] data;
    logic            rst2, trig2, ncs2, clk_en2, dv2, busy2, ovr2;
    logic [7:0]      data2;

    spi_burst_reader_if sif ();
    spi_burst_reader_if sif2 ();

    spi_burst_reader #(.NUM_BYTES(NB), .START_ADDR(SA), .POLL_PERIOD(PP), .NCS_GAP(GAP), .AUTO_POLL(1'b1)) dut (
        .clk(clk), .rst(rst), .trigger_i(trigger), .spi(sif),
        .ncs_o(ncs), .clk_enable(clk_en), .data_o(data), .data_valid(dv), .busy(busy), .overrun(ovr));

    spi_burst_reader #(.NUM_BYTES(1), .START_ADDR(8'h14), .POLL_PERIOD(PP), .NCS_GAP(4), .AUTO_POLL(1'b0)) dut2 (
        .clk(clk), .rst(rst2), .trigger_i(trig2), .spi(sif2),
        .ncs_o(ncs2), .clk_enable(clk_en2), .data_o(data2), .data_valid(dv2), .busy(busy2), .overrun(ovr2));

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_tx(input bit init, input int j);
        if (init) return (j == 0) ? 8'h0A : (j == 1) ? 8'h2D : 8'h02;
        return (j == 0) ? 8'h0B : (j == 1) ? SA : 8'h00;
    endfunction

    // Model state for the main instance
    int              pc = 0;
    int              run = GAP + 1;
    bit              pend = 1'b0;
    bit              minit = INIT_EN;
    bit              inflight = 1'b0;
    int              lat = 0;
    logic [7:0]      wtx [0:31];
    int              wn = 0;
    logic [7:0]      wrx [0:15];
    int              rxn = 0;
    bit              win_init = 1'b0;
    logic [NB*8-1:0] exp_data = '0;
    bit              ncs_prev = 1'b1;
    int              nvalid = 0;
    bit              fixed_rx = 1'b1;

    initial begin : mon
        bit r, req, tick, start_now, exp_ovr, idle_prev, gapend_prev, init_start, exp_busy, ok;
        int ri;
        logic [7:0] rx;
        sif.spi_byte_done = 1'b0;
        sif.spi_rx_data = 8'h00;
        forever begin
            @(posedge clk);
            r = rst;
            start_now = 1'b0;
            exp_ovr = 1'b0;
            init_start = 1'b0;
            idle_prev = (run > GAP) && !minit;
            gapend_prev = (run == GAP);
            if (r) begin
                pc = 0;
                pend = 1'b0;
                minit = INIT_EN;
            end else begin
                tick = (pc == PP - 1);
                pc = tick ? 0 : pc + 1;
                req = tick || trigger;
                if (minit) begin
                    start_now = 1'b1;
                    init_start = 1'b1;
                    minit = 1'b0;
                    if (req) pend = 1'b1;
                end else if (idle_prev) begin
                    if (req) start_now = 1'b1;
                end else if (gapend_prev) begin
                    if (pend) begin
                        start_now = 1'b1;
                        pend = req;
                    end else if (req) begin
                        start_now = 1'b1;
                    end
                end else if (req) begin
                    if (pend) exp_ovr = 1'b1;
                    else pend = 1'b1;
                end
            end

            @(negedge clk);
            if (r) begin
                check("reset_ctrl", ncs === 1'b1 && clk_en === 1'b0 && busy === 1'b0 && sif.start === 1'b0
                      && dv === 1'b0 && ovr === 1'b0 && sif.spi_tx_data === 8'h00,
                      64'({ncs, clk_en, busy, sif.start, dv, ovr}), 64'(6'b100000));
                check("reset_data", data === '0, 64'(data), 64'(0));
                run = GAP + 1;
                inflight = 1'b0;
                sif.spi_byte_done = 1'b0;
                wn = 0;
                rxn = 0;
                exp_data = '0;
                ncs_prev = 1'b1;
            end else begin
                if (ncs) run = (run > GAP) ? run : run + 1;
                else run = 0;
                exp_busy = !(ncs && run > GAP);
                check("clk_enable", clk_en === ~ncs, 64'(clk_en), 64'(~ncs));
                check("overrun", ovr === exp_ovr, 64'(ovr), 64'(exp_ovr));
                check("busy", busy === exp_busy, 64'(busy), 64'(exp_busy));
                if (start_now) begin
                    check("burst_start", ncs === 1'b0 && sif.start === 1'b1 && sif.spi_tx_data === exp_tx(init_start, 0),
                          64'({ncs, sif.start, sif.spi_tx_data}), 64'({1'b0, 1'b1, exp_tx(init_start, 0)}));
                    win_init = init_start;
                end else if (idle_prev || gapend_prev) begin
                    check("stay_idle", ncs === 1'b1, 64'(ncs), 64'(1));
                end
                if (!ncs_prev && ncs) begin
                    ok = (wn == (win_init ? 3 : NB + 2));
                    for (int j = 0; j < wn && j < 32; j++) if (wtx[j] !== exp_tx(win_init, j)) ok = 1'b0;
                    check("window_bytes", ok, 64'(wn), 64'(win_init ? 3 : NB + 2));
                    check("valid_at_end", dv === !win_init, 64'(dv), 64'(!win_init));
                    if (!win_init) begin
                        for (int j = 0; j < NB; j++) exp_data[8*j +: 8] = wrx[j];
                        nvalid++;
                    end
                    wn = 0;
                    rxn = 0;
                end else begin
                    check("valid_quiet", dv === 1'b0, 64'(dv), 64'(0));
                end
                check("data_o", data === exp_data, 64'(data), 64'(exp_data));

                if (sif.start) check("start_legal", !inflight && !ncs, 64'({inflight, ncs}), 64'(0));
                sif.spi_byte_done = 1'b0;
                if (inflight) begin
                    lat--;
                    if (lat == 0) begin
                        ri = wn - 3;
                        rx = (fixed_rx && ri >= 0) ? 8'((ri + 1) * 17) : 8'($urandom_range(0, 255));
                        if (!win_init && wn >= 3 && rxn < 16) begin
                            wrx[rxn] = rx;
                            rxn++;
                        end
                        sif.spi_rx_data = rx;
                        sif.spi_byte_done = 1'b1;
                        inflight = 1'b0;
                    end
                end
                if (sif.start) begin
                    if (wn < 32) wtx[wn] = sif.spi_tx_data;
                    wn++;
                    inflight = 1'b1;
                    lat = $urandom_range(1, 4);
                end
                ncs_prev = ncs;
            end
        end
    end

    // Fixed-latency engine and event counters for the second instance
    int         starts2 = 0, wins2 = 0, valids2 = 0, ovrs2 = 0, cnt2 = 0, wb2 = 0;
    logic [7:0] tx2 [0:3];
    bit         ncs2_prev = 1'b1;

    initial begin : mon2
        sif2.spi_byte_done = 1'b0;
        sif2.spi_rx_data = 8'h5A;
        forever begin
            @(negedge clk);
            if (rst2) begin
                sif2.spi_byte_done = 1'b0;
                cnt2 = 0;
                wb2 = 0;
                ncs2_prev = 1'b1;
            end else begin
                if (ncs2_prev && !ncs2) begin
                    wins2++;
                    wb2 = 0;
                end
                sif2.spi_byte_done = 1'b0;
                if (cnt2 > 0) begin
                    cnt2--;
                    if (cnt2 == 0) sif2.spi_byte_done = 1'b1;
                end
                if (sif2.start) begin
                    starts2++;
                    if (wb2 < 4) tx2[wb2] = sif2.spi_tx_data;
                    wb2++;
                    cnt2 = 2;
                end
                if (dv2) valids2++;
                if (ovr2) ovrs2++;
                ncs2_prev = ncs2;
            end
        end
    end

    initial begin : stim
        int t, nv0, w0, s0, v0, o0;
        rst = 1'b1; trigger = 1'b0; rst2 = 1'b1; trig2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        t = 0;
        while (dv !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        check("first_burst_seen", dv === 1'b1, 64'(dv), 64'(1));
        check("first_burst_data", data === 48'h665544332211, 64'(data), 64'h665544332211);
        repeat (30) @(negedge clk);
        check("single_valid", nvalid == 1, 64'(nvalid), 64'(1));

        fixed_rx = 1'b0;
        repeat (2500) begin
            @(negedge clk);
            trigger = ($urandom_range(0, 29) == 0);
        end
        trigger = 1'b0;

        t = 0;
        while (!(rxn >= 3 && ncs === 1'b0 && !win_init) && t < 2000) begin @(negedge clk); t++; end
        check("midburst_found", rxn >= 3, 64'(rxn), 64'(3));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ctrl", ncs === 1'b1 && clk_en === 1'b0 && busy === 1'b0,
              64'({ncs, clk_en, busy}), 64'(3'b100));
        check("midrst_data", data === '0, 64'(data), 64'(0));
        nv0 = nvalid;
        repeat (300) @(negedge clk);
        check("after_rst_burst", nvalid > nv0, 64'(nvalid - nv0), 64'(1));

        @(negedge clk);
        rst2 = 1'b0;
        w0 = wins2;
        repeat (3 * PP) @(negedge clk);
        check("no_auto_bursts", wins2 - w0 == int'(INIT_EN), 64'(wins2 - w0), 64'(INIT_EN));

        s0 = starts2;
        trig2 = 1'b1;
        @(negedge clk);
        trig2 = 1'b0;
        check("trigger_latency", ncs2 === 1'b0 && sif2.start === 1'b1, 64'({ncs2, sif2.start}), 64'(2'b01));
        t = 0;
        while (dv2 !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        check("burst2_seen", dv2 === 1'b1, 64'(dv2), 64'(1));
        check("burst2_data", data2 === 8'h5A, 64'(data2), 64'(8'h5A));
        repeat (10) @(negedge clk);
        check("burst2_starts", starts2 - s0 == 3, 64'(starts2 - s0), 64'(3));
        check("burst2_bytes", tx2[0] === 8'h0B && tx2[1] === 8'h14 && tx2[2] === 8'h00,
              64'({tx2[0], tx2[1], tx2[2]}), 64'(24'h0B1400));

        v0 = valids2;
        o0 = ovrs2;
        trig2 = 1'b1; @(negedge clk); trig2 = 1'b0; @(negedge clk);
        trig2 = 1'b1; @(negedge clk); trig2 = 1'b0; @(negedge clk);
        trig2 = 1'b1; @(negedge clk); trig2 = 1'b0;
        repeat (100) @(negedge clk);
        check("b2b_valids", valids2 - v0 == 2, 64'(valids2 - v0), 64'(2));
        check("b2b_overrun", ovrs2 - o0 == 1, 64'(ovrs2 - o0), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
